pipelined_reduction_tree: RTL

//   Pipelined, parametrised multi-operand adder for the approximate MAC datapath.
//   - Sums NUM_OPS unsigned W-bit partial products (8 x 16b in the edge-detect

---
 rtl/pipelined_reduction_tree.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_reduction_tree.sv
// pipelined_reduction_tree
//   Three-stage pipelined multi-operand adder. It sums NUM_OPS unsigned W-bit
//   operands with a carry-save tree followed by a carry-propagate add. Each
//   transaction can optionally approximate the low APPROX_BITS columns.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   operand set valid
//   in_ready   operand set accepted this cycle (combinational)
//   in_data    operand i at in_data[i*W +: W]
//   approx_en  per-transaction approximate mode, sampled with in_data
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   reduction result, OUT_W bits
module pipelined_reduction_tree #(
  parameter int NUM_OPS     = 8,
  parameter int W           = 16,
  parameter int APPROX_BITS = 4,
  parameter int OUT_W       = W + $clog2(NUM_OPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_OPS*W-1:0] in_data,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data
);

  // The tree gets one extra row. It carries the OR of the low columns in
  // approximate mode and is zero in exact mode.
  localparam int NR = NUM_OPS + 1;
  localparam logic [W-1:0] LOW_MASK = {W{1'b1}} >> (W - APPROX_BITS);

  // Pipeline registers
  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_OPS*W-1:0] s1_data_q;
  logic                 s1_approx_q;
  logic                 s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]     s2_sum_q, s2_carry_q;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_data_q;

  // Stage advance enables. An empty stage always advances, so bubbles collapse
  // even while the output is stalled.
  logic s1_adv, s2_adv, s3_adv;

  always_comb begin
    s3_adv      = !out_valid_q || out_ready;
    s2_adv      = !s2_valid_q || s3_adv;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_adv ? in_valid   : s1_valid_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    out_valid_d = s3_adv ? s2_valid_q : out_valid_q;
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Row preparation. In approximate mode the operands lose their low columns.
  // The OR of those columns becomes one extra row. That row and the cleared
  // operands share no set bits in the low columns, so adding them makes no
  // carry into column APPROX_BITS. The result is an exact OR below and an
  // exact shifted sum above.
  logic [W-1:0]     op_w     [NUM_OPS];
  logic [OUT_W-1:0] row_init [NR];
  logic [W-1:0]     or_low;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_rows
      assign op_w[gi]     = s1_data_q[gi*W +: W];
      assign row_init[gi] = OUT_W'(s1_approx_q ? (op_w[gi] & ~LOW_MASK) : op_w[gi]);
    end
  endgenerate

  always_comb begin
    or_low = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      or_low = or_low | (op_w[i] & LOW_MASK);
    end
  end

  assign row_init[NUM_OPS] = s1_approx_q ? OUT_W'(or_low) : '0;

  // Carry-save tree. Each level groups the rows in threes and compresses each
  // group 3:2. Rows left over from grouping pass through unchanged. The tree
  // stops once two rows remain. Every intermediate carry row is bounded by the
  // final total, which fits in OUT_W, so the <<1 never drops a set bit.
  logic [OUT_W-1:0] tree_sum, tree_carry;

  always_comb begin : csa_tree
    logic [OUT_W-1:0] cur [NR];
    logic [OUT_W-1:0] nxt [NR];
    int n;
    int g;
    n = NR;
    g = 0;
    for (int j = 0; j < NR; j++) begin
      cur[j] = row_init[j];
      nxt[j] = '0;
    end
    for (int lv = 0; lv < NR; lv++) begin
      if (n > 2) begin
        g = n / 3;
        for (int j = 0; j < NR; j++) begin
          nxt[j] = '0;
        end
        for (int k = 0; k < NR / 3; k++) begin
          if (k < g) begin
            nxt[2*k]   = cur[3*k] ^ cur[3*k+1] ^ cur[3*k+2];
            nxt[2*k+1] = ((cur[3*k] & cur[3*k+1]) | (cur[3*k] & cur[3*k+2]) |
                          (cur[3*k+1] & cur[3*k+2])) << 1;
          end
        end
        // Leftover rows land right after the 2*g compressed rows.
        for (int k = 0; k < NR; k++) begin
          if (k >= 3 * g && k < n) begin
            nxt[k-g] = cur[k];
          end
        end
        for (int j = 0; j < NR; j++) begin
          cur[j] = nxt[j];
        end
        n = n - g;
      end
    end
    tree_sum   = cur[0];
    tree_carry = cur[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_approx_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_carry_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_adv && in_valid) begin
        s1_data_q   <= in_data;
        s1_approx_q <= approx_en;
      end
      if (s2_adv && s1_valid_q) begin
        s2_sum_q   <= tree_sum;
        s2_carry_q <= tree_carry;
      end
      if (s3_adv && s2_valid_q) begin
        out_data_q <= s2_sum_q + s2_carry_q;
      end
    end
  end

endmodule
